// File: rtl/alu_dec_pkg.sv
// Shared constants for the RV32 ALU-control decoder: opcodes, ALU op encodings,
// mul/div op base and default mul/div occupancy.
package alu_dec_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_ADD    = 4'b0110,
    ALU_COPY_B = 4'b0111,
    ALU_XOR    = 4'b1000,
    ALU_OR     = 4'b1001,
    ALU_AND    = 4'b1010,
    ALU_SLL    = 4'b1011,
    ALU_SRA    = 4'b1100,
    ALU_SRL    = 4'b1101,
    ALU_SUB    = 4'b1110,
    ALU_NOP    = 4'b1111
  } alu_base_e;

  // Mul/div ops are this base OR'd with funct3 (MUL 10000 .. REMU 10111).
  localparam logic [4:0] ALU_MD_BASE    = 5'b10000;
  localparam int         MD_LAT_DEFAULT = 4;

  // Register/immediate arithmetic by funct3; sra picks SRA over SRL for 101.
  function automatic alu_base_e rtype_op(input logic [2:0] f3, input logic sra);
    case (f3)
      3'b000:  rtype_op = ALU_ADD;
      3'b001:  rtype_op = ALU_SLL;
      3'b010:  rtype_op = ALU_SLT;
      3'b011:  rtype_op = ALU_SLTU;
      3'b100:  rtype_op = ALU_XOR;
      3'b101:  rtype_op = sra ? ALU_SRA : ALU_SRL;
      3'b110:  rtype_op = ALU_OR;
      default: rtype_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec_pipe_if.sv
// Decode-to-execute bundle for alu_dec_pipe: instruction fields, flush and
// both valid/ready handshakes. The design sits on the slave modport.
interface alu_dec_pipe_if #(
  parameter int ALUOP_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               funct7b0;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [ALUOP_W-1:0] alu_op;
  logic [2:0]         br_cond;
  logic               is_branch;
  logic               illegal;
  logic               md_busy;

  modport master (
    output in_valid, opcode, funct3, funct7b5, funct7b0, flush, out_ready,
    input  in_ready, out_valid, alu_op, br_cond, is_branch, illegal, md_busy
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7b5, funct7b0, flush, out_ready,
    output in_ready, out_valid, alu_op, br_cond, is_branch, illegal, md_busy
  );
endinterface

// File: rtl/alu_dec_comb.sv
// Pure combinational RV32 ALU-control decode. Mul/div encodings are decoded
// only when ALU_DEC_MULDIV_EN is defined; otherwise they are illegal.
module alu_dec_comb
  import alu_dec_pkg::*;
#(
  parameter int ALUOP_W = 5
) (
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               funct7b0,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         br_cond,
  output logic               is_branch,
  output logic               illegal
`ifdef ALU_DEC_MULDIV_EN
 ,output logic               is_md
`endif
);

  always_comb begin
    alu_op    = ALUOP_W'(ALU_NOP);
    br_cond   = 3'b000;
    is_branch = 1'b0;
    illegal   = 1'b0;
`ifdef ALU_DEC_MULDIV_EN
    is_md     = 1'b0;
`endif
    case (opcode)
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_AUIPC:
        alu_op = ALUOP_W'(ALU_ADD);
      OPC_LUI:
        alu_op = ALUOP_W'(ALU_COPY_B);
      // Immediate forms never subtract; funct7b5 only matters for SRAI.
      OPC_OPIMM:
        alu_op = ALUOP_W'(rtype_op(funct3, funct7b5));
      OPC_OP: begin
        if (funct7b0) begin
`ifdef ALU_DEC_MULDIV_EN
          alu_op = ALUOP_W'(ALU_MD_BASE | {2'b00, funct3});
          is_md  = 1'b1;
`else
          illegal = 1'b1;
`endif
        end else if (funct3 == 3'b000 && funct7b5) begin
          alu_op = ALUOP_W'(ALU_SUB);
        end else begin
          alu_op = ALUOP_W'(rtype_op(funct3, funct7b5));
        end
      end
      OPC_BRANCH: begin
        alu_op    = ALUOP_W'(ALU_SUB);
        is_branch = 1'b1;
        br_cond   = funct3;
        illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_dec_pipe.sv
// Registered ALU-control decoder between decode and execute, with valid/ready
// handshake, flush, and mul/div occupancy tracking under ALU_DEC_MULDIV_EN.
module alu_dec_pipe
  import alu_dec_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int MD_LAT  = MD_LAT_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  alu_dec_pipe_if.slave bus
);

  if (MD_LAT < 1) begin : g_chk_lat
    $error("alu_dec_pipe: MD_LAT must be at least 1");
  end
`ifdef ALU_DEC_MULDIV_EN
  if (ALUOP_W < 5) begin : g_chk_w
    $error("alu_dec_pipe: ALUOP_W must be at least 5 with mul/div");
  end
`else
  if (ALUOP_W < 4) begin : g_chk_w
    $error("alu_dec_pipe: ALUOP_W must be at least 4");
  end
`endif

  logic [ALUOP_W-1:0] dec_alu_op;
  logic [2:0]         dec_br_cond;
  logic               dec_is_branch;
  logic               dec_illegal;

  logic               out_valid_q, out_valid_d;
  logic [ALUOP_W-1:0] alu_op_q,    alu_op_d;
  logic [2:0]         br_cond_q,   br_cond_d;
  logic               is_branch_q, is_branch_d;
  logic               illegal_q,   illegal_d;

  logic               in_ready;
  logic               accept;
  logic               xfer_out;
  logic               md_busy;

`ifdef ALU_DEC_MULDIV_EN
  logic dec_is_md;
`endif

  alu_dec_comb #(
    .ALUOP_W (ALUOP_W)
  ) u_comb (
    .opcode    (bus.opcode),
    .funct3    (bus.funct3),
    .funct7b5  (bus.funct7b5),
    .funct7b0  (bus.funct7b0),
    .alu_op    (dec_alu_op),
    .br_cond   (dec_br_cond),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
`ifdef ALU_DEC_MULDIV_EN
   ,.is_md     (dec_is_md)
`endif
  );

  assign in_ready = !bus.flush && !md_busy && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign xfer_out = out_valid_q && bus.out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    br_cond_d   = br_cond_q;
    is_branch_d = is_branch_q;
    illegal_d   = illegal_q;
    if (bus.flush)    out_valid_d = 1'b0;
    else if (accept)  out_valid_d = 1'b1;
    else if (xfer_out) out_valid_d = 1'b0;
    if (accept) begin
      alu_op_d    = dec_alu_op;
      br_cond_d   = dec_br_cond;
      is_branch_d = dec_is_branch;
      illegal_d   = dec_illegal;
    end
  end

  // Output register: fields only reload on accept so they hold under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= ALUOP_W'(ALU_NOP);
      br_cond_q   <= 3'b000;
      is_branch_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      br_cond_q   <= br_cond_d;
      is_branch_q <= is_branch_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef ALU_DEC_MULDIV_EN
  localparam int CNT_W = $clog2(MD_LAT + 1);

  logic             md_q,     md_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  // Counter starts when a mul/div op leaves for execute; MD_LAT=1 loads zero.
  always_comb begin
    md_d     = accept ? dec_is_md : md_q;
    md_cnt_d = md_cnt_q;
    if (bus.flush)               md_cnt_d = '0;
    else if (xfer_out && md_q)   md_cnt_d = CNT_W'(MD_LAT - 1);
    else if (md_cnt_q != '0)     md_cnt_d = md_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_q     <= 1'b0;
      md_cnt_q <= '0;
    end else begin
      md_q     <= md_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = (md_cnt_q != '0);
`else
  assign md_busy = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.br_cond   = br_cond_q;
  assign bus.is_branch = is_branch_q;
  assign bus.illegal   = illegal_q;
  assign bus.md_busy   = md_busy;

endmodule

// File: tb/tb_alu_dec_pipe.sv
// Self-checking bench for alu_dec_pipe: directed scenarios plus a randomized
// run against a queue-based reference model. Honours ALU_DEC_MULDIV_EN.
module tb_alu_dec_pipe;

  localparam int MDL = 4;
`ifdef ALU_DEC_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] op;
    logic [2:0] br;
    logic       isb;
    logic       ill;
    logic       md;
  } exp_t;

  typedef struct packed {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       b5;
    logic       b0;
    logic [4:0] op;
    logic [2:0] br;
    logic       isb;
    logic       ill;
  } vec_t;

  // ALU op for each funct3 when neither SUB nor SRA applies.
  localparam logic [4:0] ROPS [8] = '{5'h06, 5'h0B, 5'h02, 5'h03, 5'h08, 5'h0D, 5'h09, 5'h0A};

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_dec_pipe_if #(.ALUOP_W(5)) bus ();

  alu_dec_pipe #(
    .ALUOP_W (5),
    .MD_LAT  (MDL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic b5, input logic b0);
    exp_t e;
    e = '{op: 5'h0F, br: 3'd0, isb: 1'b0, ill: 1'b1, md: 1'b0};
    if (opc == 7'h03 || opc == 7'h23 || opc == 7'h6F || opc == 7'h67 || opc == 7'h17) begin
      e.op = 5'h06; e.ill = 1'b0;
    end else if (opc == 7'h37) begin
      e.op = 5'h07; e.ill = 1'b0;
    end else if (opc == 7'h13) begin
      e.op = (f3 == 3'd5 && b5) ? 5'h0C : ROPS[f3]; e.ill = 1'b0;
    end else if (opc == 7'h33) begin
      if (b0) begin
        if (MD_EN) begin e.op = {2'b10, f3}; e.ill = 1'b0; e.md = 1'b1; end
      end else begin
        e.ill = 1'b0;
        if (b5 && f3 == 3'd0)      e.op = 5'h0E;
        else if (b5 && f3 == 3'd5) e.op = 5'h0C;
        else                       e.op = ROPS[f3];
      end
    end else if (opc == 7'h63) begin
      e.op = 5'h0E; e.isb = 1'b1; e.br = f3; e.ill = (f3 == 3'd2 || f3 == 3'd3);
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                       input logic b5, input logic b0, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.opcode    = opc;
    bus.funct3    = f3;
    bus.funct7b5  = b5;
    bus.funct7b0  = b0;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.alu_op !== 5'h0F) begin bad++; $display("FAIL reset_alu_op: got %h want 0f", bus.alu_op); end
    total++; if (bus.br_cond !== 3'd0) begin bad++; $display("FAIL reset_br_cond: got %h want 0", bus.br_cond); end
    total++; if (bus.is_branch !== 1'b0) begin bad++; $display("FAIL reset_is_branch: got %b want 0", bus.is_branch); end
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
    total++; if (bus.md_busy !== 1'b0) begin bad++; $display("FAIL reset_md_busy: got %b want 0", bus.md_busy); end
    rst = 1'b0;
  endtask

  task automatic test_decode();
    vec_t tbl [12];
    tbl[0]  = '{7'h33, 3'd0, 1'b0, 1'b0, 5'h06, 3'd0, 1'b0, 1'b0}; // ADD
    tbl[1]  = '{7'h33, 3'd0, 1'b1, 1'b0, 5'h0E, 3'd0, 1'b0, 1'b0}; // SUB
    tbl[2]  = '{7'h13, 3'd5, 1'b1, 1'b0, 5'h0C, 3'd0, 1'b0, 1'b0}; // SRAI
    tbl[3]  = '{7'h13, 3'd5, 1'b0, 1'b0, 5'h0D, 3'd0, 1'b0, 1'b0}; // SRLI
    tbl[4]  = '{7'h63, 3'd0, 1'b0, 1'b0, 5'h0E, 3'd0, 1'b1, 1'b0}; // BEQ
    tbl[5]  = '{7'h63, 3'd2, 1'b0, 1'b0, 5'h0E, 3'd2, 1'b1, 1'b1}; // branch funct3 010
    tbl[6]  = '{7'h13, 3'd0, 1'b1, 1'b0, 5'h06, 3'd0, 1'b0, 1'b0}; // ADDI, b5 set
    tbl[7]  = '{7'h37, 3'd5, 1'b1, 1'b0, 5'h07, 3'd0, 1'b0, 1'b0}; // LUI
    tbl[8]  = '{7'h33, 3'd3, 1'b0, 1'b0, 5'h03, 3'd0, 1'b0, 1'b0}; // SLTU
    tbl[9]  = '{7'h7F, 3'd0, 1'b0, 1'b0, 5'h0F, 3'd0, 1'b0, 1'b1}; // unknown opcode
    tbl[10] = '{7'h23, 3'd2, 1'b0, 1'b0, 5'h06, 3'd0, 1'b0, 1'b0}; // SW
    tbl[11] = '{7'h63, 3'd7, 1'b0, 1'b0, 5'h0E, 3'd7, 1'b1, 1'b0}; // BGEU
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].opc, tbl[i].f3, tbl[i].b5, tbl[i].b0, 1'b1, 1'b0);
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL dec_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
      tick();
      total++;
      if ({bus.out_valid, bus.alu_op, bus.br_cond, bus.is_branch, bus.illegal} !==
          {1'b1, tbl[i].op, tbl[i].br, tbl[i].isb, tbl[i].ill}) begin
        bad++;
        $display("FAIL dec[%0d]: got v=%b op=%h br=%h isb=%b ill=%b want v=1 op=%h br=%h isb=%b ill=%b",
                 i, bus.out_valid, bus.alu_op, bus.br_cond, bus.is_branch, bus.illegal,
                 tbl[i].op, tbl[i].br, tbl[i].isb, tbl[i].ill);
      end
    end
    drive(1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL dec_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    drive(1'b1, 7'h33, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0); // XOR
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 7'h33, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0); // OR offered while stalled
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, bus.in_ready); end
      tick();
      total++; if ({bus.out_valid, bus.alu_op} !== {1'b1, 5'h08}) begin bad++; $display("FAIL stall_hold[%0d]: got v=%b op=%h want v=1 op=08", k, bus.out_valid, bus.alu_op); end
    end
    drive(1'b1, 7'h33, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready); end
    tick();
    total++; if ({bus.out_valid, bus.alu_op} !== {1'b1, 5'h09}) begin bad++; $display("FAIL stall_next: got v=%b op=%h want v=1 op=09", bus.out_valid, bus.alu_op); end
    drive(1'b1, 7'h33, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0); // AND
    tick();
    total++; if ({bus.out_valid, bus.alu_op} !== {1'b1, 5'h0A}) begin bad++; $display("FAIL stall_b2b: got v=%b op=%h want v=1 op=0a", bus.out_valid, bus.alu_op); end
    drive(1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 7'h33, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 7'h33, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_kill: got %b want 0", bus.out_valid); end
    drive(1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_accept: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_muldiv();
    drive(1'b1, 7'h33, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0); // DIV
    tick();
`ifdef ALU_DEC_MULDIV_EN
    total++; if ({bus.out_valid, bus.alu_op, bus.illegal} !== {1'b1, 5'h14, 1'b0}) begin bad++; $display("FAIL md_div: got v=%b op=%h ill=%b want v=1 op=14 ill=0", bus.out_valid, bus.alu_op, bus.illegal); end
    drive(1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < MDL - 1; k++) begin
      total++; if (bus.md_busy !== 1'b1) begin bad++; $display("FAIL md_busy[%0d]: got %b want 1", k, bus.md_busy); end
      drive(1'b1, 7'h33, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL md_in_ready[%0d]: got %b want 0", k, bus.in_ready); end
      tick();
    end
    total++; if (bus.md_busy !== 1'b0) begin bad++; $display("FAIL md_idle: got %b want 0", bus.md_busy); end
    tick();
    total++; if ({bus.out_valid, bus.alu_op} !== {1'b1, 5'h06}) begin bad++; $display("FAIL md_after: got v=%b op=%h want v=1 op=06", bus.out_valid, bus.alu_op); end
    drive(1'b1, 7'h33, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if (bus.md_busy !== 1'b1) begin bad++; $display("FAIL md_busy2: got %b want 1", bus.md_busy); end
    drive(1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    total++; if (bus.md_busy !== 1'b0) begin bad++; $display("FAIL md_flush: got %b want 0", bus.md_busy); end
    drive(1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    total++; if ({bus.out_valid, bus.alu_op, bus.illegal} !== {1'b1, 5'h0F, 1'b1}) begin bad++; $display("FAIL md_div_off: got v=%b op=%h ill=%b want v=1 op=0f ill=1", bus.out_valid, bus.alu_op, bus.illegal); end
    drive(1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < MDL; k++) begin
      tick();
      total++; if (bus.md_busy !== 1'b0) begin bad++; $display("FAIL md_off_busy[%0d]: got %b want 0", k, bus.md_busy); end
    end
`endif
  endtask

  task automatic test_random();
    exp_t       q[$];
    exp_t       e;
    exp_t       head;
    int         mcnt;
    int         k;
    logic       v, b5, b0, ordy, fl, exp_rdy, popped_md;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] pool [10];
    pool = '{7'h03, 7'h23, 7'h6F, 7'h67, 7'h17, 7'h37, 7'h13, 7'h33, 7'h63, 7'h33};
    rst = 1'b1;
    drive(1'b0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    mcnt = 0;
    for (int c = 0; c < 600; c++) begin
      total++; if (bus.out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, bus.out_valid, (q.size() != 0)); end
      if (q.size() != 0) begin
        head = q[0];
        total++;
        if ({bus.alu_op, bus.br_cond, bus.is_branch, bus.illegal} !== {head.op, head.br, head.isb, head.ill}) begin
          bad++;
          $display("FAIL rnd_fields@%0d: got op=%h br=%h isb=%b ill=%b want op=%h br=%h isb=%b ill=%b",
                   c, bus.alu_op, bus.br_cond, bus.is_branch, bus.illegal, head.op, head.br, head.isb, head.ill);
        end
      end
      total++; if (bus.md_busy !== (mcnt != 0)) begin bad++; $display("FAIL rnd_md_busy@%0d: got %b want %b", c, bus.md_busy, (mcnt != 0)); end

      k    = int'($urandom_range(0, 10));
      opc  = (k == 10) ? 7'($urandom) : pool[k];
      f3   = 3'($urandom_range(0, 7));
      b5   = 1'($urandom_range(0, 1));
      b0   = ($urandom_range(0, 3) == 0);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      drive(v, opc, f3, b5, b0, ordy, fl);
      #1;
      exp_rdy = !fl && (mcnt == 0) && (q.size() == 0 || ordy);
      total++; if (bus.in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, bus.in_ready, exp_rdy); end

      e = ref_decode(opc, f3, b5, b0);
      if (fl) begin
        q.delete();
        mcnt = 0;
      end else begin
        popped_md = 1'b0;
        if (q.size() != 0 && ordy) begin
          head = q.pop_front();
          popped_md = head.md;
        end
        if (popped_md)     mcnt = MDL - 1;
        else if (mcnt > 0) mcnt = mcnt - 1;
        if (v && exp_rdy) q.push_back(e);
      end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_decode();
    test_stall();
    test_flush();
    test_muldiv();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
